// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with EX/MEM and MEM/WB operand
//            forwarding, load-use stall detection and flush.
//            Optional perf counters enabled by `define ID_EX_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int          XLEN   = 32,
    parameter logic [31:0] NOP_IR = 32'h00000013
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    input  logic            iVALID,
    output logic            oREADY,
    input  logic [31:0]     iIR,
    input  logic [XLEN-1:0] iRS1_DATA,
    input  logic [XLEN-1:0] iRS2_DATA,
    input  logic            iFLUSH,
    input  logic            iEXM_WE,
    input  logic            iEXM_LOAD,
    input  logic [4:0]      iEXM_RD,
    input  logic [XLEN-1:0] iEXM_DATA,
    input  logic            iMWB_WE,
    input  logic [4:0]      iMWB_RD,
    input  logic [XLEN-1:0] iMWB_DATA,
    output logic            oVALID,
    input  logic            iREADY,
    output logic [31:0]     oIR,
    output logic [XLEN-1:0] oALU_IN1,
    output logic [XLEN-1:0] oALU_IN2,
    output logic [31:0]     oSTALL_CNT,
    output logic [31:0]     oISSUE_CNT
);

    logic            r_valid;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_aluIn1;
    logic [XLEN-1:0] r_aluIn2;

    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_fwd1;
    logic [XLEN-1:0] w_fwd2;
    logic            w_hazard;
    logic            w_ready;
    logic            w_capture;
    logic            w_drain;

    assign w_rs1 = iIR[19:15];
    assign w_rs2 = iIR[24:20];

    // x0 reads as zero; the youngest producer (EX/MEM) wins over MEM/WB.
    function automatic logic [XLEN-1:0] fwdSel(input logic [4:0]      rs,
                                               input logic [XLEN-1:0] rfData);
        logic [XLEN-1:0] sel;
        sel = rfData;
        if (rs == 5'd0)
            sel = '0;
        else if (iEXM_WE && (iEXM_RD == rs))
            sel = iEXM_DATA;
        else if (iMWB_WE && (iMWB_RD == rs))
            sel = iMWB_DATA;
        return sel;
    endfunction

    always_comb begin
        w_fwd1 = fwdSel(w_rs1, iRS1_DATA);
        w_fwd2 = fwdSel(w_rs2, iRS2_DATA);
    end

    assign w_hazard  = iVALID & iEXM_LOAD & iEXM_WE & (iEXM_RD != 5'd0) &
                       ((iEXM_RD == w_rs1) | (iEXM_RD == w_rs2));
    assign w_ready   = (~r_valid | iREADY) & ~w_hazard;
    assign w_capture = iVALID & w_ready & ~iFLUSH;
    assign w_drain   = r_valid & iREADY;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_valid  <= 1'b0;
            r_ir     <= NOP_IR;
            r_aluIn1 <= '0;
            r_aluIn2 <= '0;
        end else if (iFLUSH) begin
            r_valid  <= 1'b0;
            r_ir     <= NOP_IR;
        end else if (w_capture) begin
            r_valid  <= 1'b1;
            r_ir     <= iIR;
            r_aluIn1 <= w_fwd1;
            r_aluIn2 <= w_fwd2;
        end else if (w_drain) begin
            r_valid  <= 1'b0;
            r_ir     <= NOP_IR;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_issueCnt;

    // Flush deliberately leaves the counters alone; only reset clears them.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_stallCnt <= 32'd0;
            r_issueCnt <= 32'd0;
        end else begin
            if (w_hazard)
                r_stallCnt <= r_stallCnt + 32'd1;
            if (w_drain)
                r_issueCnt <= r_issueCnt + 32'd1;
        end
    end

    assign oSTALL_CNT = r_stallCnt;
    assign oISSUE_CNT = r_issueCnt;
`else
    assign oSTALL_CNT = 32'd0;
    assign oISSUE_CNT = 32'd0;
`endif

    assign oREADY   = w_ready;
    assign oVALID   = r_valid;
    assign oIR      = r_ir;
    assign oALU_IN1 = r_aluIn1;
    assign oALU_IN2 = r_aluIn2;

endmodule

`default_nettype wire
